// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - ADC conversion pacer with req/rdy capture and error flags; optional ADC_RDY_SYNC_EN
module adc_sample_sequencer #(
    parameter int SAMPLE_DIV  = 16,
    parameter int RDY_TIMEOUT = 8,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear_err,
    input  logic          adc_rdy,
    input  logic [DW-1:0] adc_dat,
    output logic          adc_req,
    output logic          smp_valid,
    output logic [DW-1:0] smp_data,
    output logic [31:0]   smp_time,
    output logic [15:0]   smp_count,
    output logic          timeout_err,
    output logic          overrun_err,
    output logic          busy
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int WW = $clog2(RDY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        WAIT_RDY = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   timer;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wait_cnt;
    logic          tick;
    logic          rdy_s;

`ifdef ADC_RDY_SYNC_EN
    logic [1:0] rdy_sync;

    // Two-flop synchroniser for an adc_rdy that is asynchronous to clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_sync <= 2'b00;
        end else begin
            rdy_sync <= {rdy_sync[0], adc_rdy};
        end
    end

    assign rdy_s = rdy_sync[1];
`else
    assign rdy_s = adc_rdy;
`endif

    assign tick = (cnt == CW'(SAMPLE_DIV - 1));

    // Free-running timestamp and the sample-period divider (parked at 0 when disabled)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 32'd0;
            cnt   <= '0;
        end else begin
            timer <= timer + 32'd1;
            if (!enable) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Handshake FSM; every output is a register so the ADC and cache see glitch-free levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            adc_req     <= 1'b0;
            smp_valid   <= 1'b0;
            smp_data    <= '0;
            smp_time    <= 32'd0;
            smp_count   <= 16'd0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            smp_valid <= 1'b0;

            // Clear first so a flag being set later in this cycle overrides it
            if (clear_err) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end

            // A tick that lands on an active handshake is dropped and flagged
            if (tick && (state == WAIT_RDY || state == DRAIN)) begin
                overrun_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick && !rdy_s) begin
                        state    <= WAIT_RDY;
                        adc_req  <= 1'b1;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (rdy_s) begin
                        state     <= DRAIN;
                        adc_req   <= 1'b0;
                        smp_data  <= adc_dat;
                        smp_time  <= timer;
                        smp_valid <= 1'b1;
                        smp_count <= smp_count + 16'd1;
                    end else if (wait_cnt == WW'(RDY_TIMEOUT - 1)) begin
                        state       <= DRAIN;
                        adc_req     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Wait for the ADC to release rdy before a new request may go out
                    if (!rdy_s) begin
                        state <= enable ? READY : IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    adc_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb/tb_adc_sample_sequencer.sv - directed bench for adc_sample_sequencer
module tb_adc_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_err;
    logic        adc_rdy;
    logic [7:0]  adc_dat;
    logic        adc_req;
    logic        smp_valid;
    logic [7:0]  smp_data;
    logic [31:0] smp_time;
    logic [15:0] smp_count;
    logic        timeout_err;
    logic        overrun_err;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    // ADC model controls
    int         m_delay = 3;
    int         m_hold  = 0;
    logic       m_never = 1'b0;
    logic [7:0] m_dat   = 8'hD5;

    // Monitor state
    int   edges      = 0;
    logic prev_req   = 1'b0;
    logic prev_valid = 1'b0;
    int   req_rises  = 0;
    int   last_rise  = 0;
    int   cur_len    = 0;
    int   last_len   = 0;
    int   valid_cnt  = 0;
    int   consec_err = 0;

    adc_sample_sequencer #(
        .SAMPLE_DIV (16),
        .RDY_TIMEOUT(8),
        .DW         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear_err  (clear_err),
        .adc_rdy    (adc_rdy),
        .adc_dat    (adc_dat),
        .adc_req    (adc_req),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .smp_time   (smp_time),
        .smp_count  (smp_count),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release: equals the DUT timer value
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    always @(negedge clk) begin
        prev_req   <= adc_req;
        prev_valid <= smp_valid;
        if (adc_req && !prev_req) begin
            req_rises <= req_rises + 1;
            last_rise <= edges;
        end
        if (adc_req) begin
            cur_len <= cur_len + 1;
        end else if (prev_req) begin
            last_len <= cur_len;
            cur_len  <= 0;
        end
        if (smp_valid) valid_cnt <= valid_cnt + 1;
        if (smp_valid && prev_valid) consec_err <= consec_err + 1;
    end

    // Synchronous 4-phase ADC model driven on the falling edge
    initial begin
        int phase;
        int dly;
        phase   = 0;
        dly     = 0;
        adc_rdy = 1'b0;
        adc_dat = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                adc_rdy = 1'b0;
                phase   = 0;
            end else begin
                case (phase)
                    0: if (adc_req) begin
                        if (m_never) begin
                            phase = 3;
                        end else begin
                            dly   = m_delay;
                            phase = 1;
                        end
                    end
                    1: begin
                        dly = dly - 1;
                        if (dly == 0) begin
                            adc_rdy = 1'b1;
                            adc_dat = m_dat;
                            phase   = 2;
                        end
                    end
                    2: if (!adc_req) begin
                        dly   = m_hold;
                        phase = 4;
                    end
                    3: if (!adc_req) phase = 0;
                    4: begin
                        if (dly == 0) begin
                            adc_rdy = 1'b0;
                            phase   = 0;
                        end else begin
                            dly = dly - 1;
                        end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the falling edge that follows clock edge k
    task automatic goto(input int k);
        int guard;
        guard = 0;
        while (edges < k && guard < 2000) begin
            @(negedge clk);
            guard = guard + 1;
        end
        if (edges < k) check("goto_bound", edges, k);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",     adc_req,     0);
        check("rst_valid",   smp_valid,   0);
        check("rst_count",   smp_count,   0);
        check("rst_time",    smp_time,    0);
        check("rst_busy",    busy,        0);
        check("rst_tmo",     timeout_err, 0);
        check("rst_ovr",     overrun_err, 0);
        reset = 1'b0;

        // 1: normal capture
        goto(16);
        check("t1_req_up",   adc_req,   1);
        check("t1_rise_at",  last_rise, 16);
        check("t1_busy",     busy,      1);
        goto(19);
        check("t1_no_valid", smp_valid, 0);
        goto(20);
        check("t1_valid",    smp_valid, 1);
        check("t1_data",     smp_data,  8'hD5);
        check("t1_count",    smp_count, 1);
        check("t1_time",     smp_time,  19);
        check("t1_req_dn",   adc_req,   0);
        goto(21);
        check("t1_pulse",    smp_valid, 0);
        m_never = 1'b1;

        // 2 and 6: timeout with clear_err collisions
        goto(32);
        check("t1_next_rise", last_rise, 32);
        goto(39);
        check("t2_req_hold", adc_req,     1);
        check("t2_tmo_pre",  timeout_err, 0);
        clear_err = 1'b1;
        goto(40);
        check("t2_req_len",  last_len,    8);
        check("t2_req_dn",   adc_req,     0);
        check("t6_set_wins", timeout_err, 1);
        goto(41);
        check("t6_cleared",  timeout_err, 0);
        clear_err = 1'b0;
        m_never = 1'b0;
        m_dat   = 8'hA7;
        m_hold  = 20;
        goto(48);
        check("t2_next_rise", last_rise, 48);
        check("t2_no_sample", valid_cnt, 1);

        // 3: rdy held long after capture
        goto(52);
        check("t3_data",     smp_data,  8'hA7);
        check("t3_count",    smp_count, 2);
        check("t3_time",     smp_time,  51);
        goto(63);
        check("t3_ovr_pre",  overrun_err, 0);
        goto(64);
        check("t3_ovr_set",  overrun_err, 1);
        check("t3_no_req",   adc_req,     0);
        goto(70);
        check("t3_busy",     busy, 1);
        goto(75);
        check("t3_idle",     busy, 0);
        check("t3_rises",    req_rises, 3);
        m_hold = 0;
        m_dat  = 8'h3C;
        goto(80);
        check("t3_rise_at",  last_rise, 80);
        check("t3_rises2",   req_rises, 4);

        // 4: enable dropped mid-handshake
        goto(81);
        enable = 1'b0;
        goto(84);
        check("t4_valid",    smp_valid, 1);
        check("t4_data",     smp_data,  8'h3C);
        check("t4_count",    smp_count, 3);
        check("t4_time",     smp_time,  83);
        goto(120);
        check("t4_req_off",  adc_req,   0);
        check("t4_rises",    req_rises, 4);
        check("t4_busy",     busy,      0);
        check("t4_samples",  valid_cnt, 3);

        // 5: reset during WAIT_RDY
        enable  = 1'b1;
        m_never = 1'b1;
        goto(136);
        check("t5_rise_at",  last_rise, 136);
        goto(138);
        check("t5_req_pre",  adc_req,     1);
        check("t5_ovr_pre",  overrun_err, 1);
        reset = 1'b1;
        #1;
        check("t5_req_async", adc_req,    0);
        check("t5_count",    smp_count,   0);
        check("t5_data",     smp_data,    0);
        check("t5_time",     smp_time,    0);
        check("t5_ovr",      overrun_err, 0);
        check("t5_busy",     busy,        0);
        repeat (3) @(negedge clk);
        m_never = 1'b0;
        m_dat   = 8'h5A;
        #1;
        reset = 1'b0;
        goto(16);
        check("t5_rise_again", last_rise, 16);
        goto(20);
        check("t5_data2",    smp_data,  8'h5A);
        check("t5_count2",   smp_count, 1);
        check("t5_time2",    smp_time,  19);
        check("t5_samples",  valid_cnt, 4);

        goto(24);
        check("valid_consec", consec_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
